mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage between the execute stage and the write-back stage of the 5-stage MIPS core.
- Accepts the execute-stage result bundle and captures the synchronous data-SRAM read word. The SRAM address is issued by the execute stage one cycle earlier.
- Performs byte/halfword/word load extraction with sign or zero extension, then forwards the final result to write-back.
- Publishes a bypass bundle back to decode for hazard resolution.

Parameters:
- ES_TO_MS_BUS_WD, 74, width of the incoming execute bundle.
- MS_TO_WS_BUS_WD, 70, width of the outgoing write-back bundle.
- MS_TO_DS_BUS_WD, 38, width of the bypass bundle to decode.

Ports:
- clk  in  1  stage clock.
- reset  in  1  asynchronous, active-low reset: 0 resets the stage immediately, independent of clk.
- ws_allowin  in  1  write-back stage can accept this cycle.
- ms_allowin  out  1  this stage can accept this cycle.
- es_to_ms_valid  in  1  execute bundle valid.
- es_to_ms_bus  in  74  fields:
  - [73:71] ld_type: 000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu; other codes treated as lw.
  - [70] res_from_mem.
  - [69] gr_we.
  - [68:64] dest.
  - [63:32] alu_result (also the memory address).
  - [31:0] pc.
- data_sram_rdata  in  32  read word. Valid only in the cycle after the execute stage drove the address, i.e. the first cycle an instruction occupies this stage.
- ms_to_ws_valid  out  1  bundle to write-back valid.
- ms_to_ws_bus  out  70  fields: {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}.
- ms_to_ds_bus  out  38  fields: {ms_valid&gr_we [37], dest[36:32], final_result[31:0]}.

Behaviour:
- Reset (reset==0, asynchronous):
  - State: ms_valid=0, bundle register=0, first_cycle=0, rbuf_valid=0, rbuf=0.
  - Resulting outputs: ms_allowin=1, ms_to_ws_valid=0, ms_to_ds_bus=0, ms_to_ws_bus=0.
  - Reset asserted mid-stall discards the held instruction and any buffered read data.
- Handshake:
  - ms_ready_go=1.
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
  - ms_to_ws_valid = ms_valid && ms_ready_go.
- Acceptance:
  - On clk rising edge with ms_allowin=1: ms_valid <= es_to_ms_valid.
  - The bundle register loads only when es_to_ms_valid && ms_allowin; otherwise it holds.
- first_cycle flag:
  - Set to 1 on an accepted transfer, otherwise 0.
  - Marks the single cycle in which data_sram_rdata belongs to the instruction held here.
- Read-data skid buffer:
  - Capture: if ms_valid && first_cycle && !ws_allowin, then rbuf <= data_sram_rdata and rbuf_valid <= 1. Needed because the SRAM output thereafter reflects the younger instruction's address.
  - Clear: rbuf_valid <= 0 whenever ms_allowin=1, whether the instruction leaves or the stage is empty.
  - Accepting a new instruction in the same edge as the clear leaves rbuf_valid=0.
- Effective read word: mem_word = rbuf_valid ? rbuf : data_sram_rdata.
- Load extraction, with a = alu_result[1:0]:
  - lw: mem_word.
  - lb / lbu: byte a, i.e. mem_word[8a+7:8a]; sign- or zero-extended to 32 bits.
  - lh / lhu: halfword selected by a[1] (a[0] ignored); sign- or zero-extended.
  - No alignment exceptions are raised in this stage.
- final_result = res_from_mem ? load_result : alu_result.
- Output buses:
  - ms_to_ws_bus and ms_to_ds_bus are driven combinationally from the bundle register and mem_word.
  - The ms_to_ds_bus write-enable bit is gated by ms_valid.
- Back-to-back: with ws_allowin=1 continuously, one instruction per cycle passes with 1-cycle stage latency; the skid buffer is never written.
- Stall longer than one cycle: rbuf holds its value. Later changes on data_sram_rdata have no effect on final_result until the instruction leaves.
- Bubble: es_to_ms_valid=0 with ms_allowin=1 empties the stage. The bundle register holds stale data but all outputs are gated by ms_valid.

Test Plan:
- Reset low mid-operation, asynchronously between clock edges, with a valid lw held -> ms_to_ws_valid=0, ms_to_ds_bus=0, ms_allowin=1 immediately.
- lw, addr 0x100, rdata 0x8765_4321, ws_allowin=1 -> next cycle ms_to_ws_valid=1, final_result=0x8765_4321, dest/pc forwarded.
- rdata 0x80FF_7F01, addr low bits 0..3:
  - lb -> 0x0000_0001, 0x0000_007F, 0xFFFF_FFFF, 0xFFFF_FF80.
  - lbu, addr low bits 3 -> 0x0000_0080.
  - lh, addr low bits 2 -> 0xFFFF_80FF.
  - lhu, addr low bits 0 -> 0x0000_7F01.
- lw accepted with rdata=0xDEAD_BEEF, ws_allowin=0 for 3 cycles, rdata changed to 0x1234_5678 from cycle 2:
  - final_result stays 0xDEAD_BEEF throughout.
  - ms_allowin=0 during the stall.
  - The instruction issues to write-back on the first cycle ws_allowin=1.
- Non-load ALU op (res_from_mem=0, alu_result=0x0000_0042, gr_we=1, dest=5) -> ms_to_ds_bus={1, 5, 0x42}; ms_to_ds_bus[37]=0 once the stage empties.
- Stream of 4 back-to-back lw with ws_allowin=1 -> 4 consecutive valid outputs, each carrying its own cycle's rdata; rbuf_valid never asserted.

Source files
------------

// File: rtl/mem_stage_if.sv
// Handshake and data bundle signals around the memory-access stage.
// The stage itself uses the slave view. An upstream/downstream driver
// (or a bench) uses the master view.
interface mem_stage_if #(
  parameter int ES_TO_MS_BUS_WD = 74,
  parameter int MS_TO_WS_BUS_WD = 70,
  parameter int MS_TO_DS_BUS_WD = 38
);
  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic                       ms_allowin;
  logic                       ws_allowin;
  logic [31:0]                data_sram_rdata;
  logic                       ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus;

  modport slave (
    input  es_to_ms_valid, es_to_ms_bus, ws_allowin, data_sram_rdata,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_bus
  );

  modport master (
    output es_to_ms_valid, es_to_ms_bus, ws_allowin, data_sram_rdata,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_bus
  );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory-access stage: holds the execute bundle, extracts the load
// result from the synchronous SRAM read word, and forwards to write-back
// and (as a bypass) to decode. A one-word skid buffer keeps the read data
// alive when write-back stalls the instruction past its first cycle.
module mem_stage (
  input  logic         clk,
  input  logic         reset,   // asynchronous, active-low
  mem_stage_if.slave   ms_if
);
  localparam int ES_TO_MS_BUS_WD = 74;

  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LBU = 3'b010;
  localparam logic [2:0] LD_LH  = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;

  logic                       r_ms_valid;
  logic                       r_first_cycle;
  logic [ES_TO_MS_BUS_WD-1:0] r_es_bus;
  logic                       r_rbuf_valid;
  logic [31:0]                r_rbuf;

  logic        w_ms_ready_go;
  logic        w_ms_allowin;
  logic        w_accept;
  logic [2:0]  w_ld_type;
  logic        w_res_from_mem;
  logic        w_gr_we;
  logic [4:0]  w_dest;
  logic [31:0] w_alu_result;
  logic [31:0] w_pc;
  logic [1:0]  w_addr_lo;
  logic [31:0] w_mem_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_result;
  logic [31:0] w_final_result;

  assign w_ms_ready_go = 1'b1;
  assign w_ms_allowin  = !r_ms_valid || (w_ms_ready_go && ms_if.ws_allowin);
  assign w_accept      = ms_if.es_to_ms_valid && w_ms_allowin;

  assign w_ld_type      = r_es_bus[73:71];
  assign w_res_from_mem = r_es_bus[70];
  assign w_gr_we        = r_es_bus[69];
  assign w_dest         = r_es_bus[68:64];
  assign w_alu_result   = r_es_bus[63:32];
  assign w_pc           = r_es_bus[31:0];
  assign w_addr_lo      = w_alu_result[1:0];

  // Stage occupancy, first-cycle marker and bundle capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ms_valid    <= 1'b0;
      r_first_cycle <= 1'b0;
      r_es_bus      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (w_ms_allowin) r_ms_valid <= ms_if.es_to_ms_valid;
      r_first_cycle <= w_accept;
      if (w_accept) r_es_bus <= ms_if.es_to_ms_bus;
    end
  end

  // Skid buffer: keep the read word once the SRAM output moves on to the next address
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rbuf_valid <= 1'b0;
      r_rbuf       <= '0;
    end else if (w_ms_allowin) begin
      r_rbuf_valid <= 1'b0;
    end else if (r_ms_valid && r_first_cycle && !ms_if.ws_allowin) begin
      r_rbuf_valid <= 1'b1;
      r_rbuf       <= ms_if.data_sram_rdata;
    end
  end

  assign w_mem_word = r_rbuf_valid ? r_rbuf : ms_if.data_sram_rdata;
  assign w_byte     = w_mem_word[{w_addr_lo, 3'b000} +: 8];
  assign w_half     = w_addr_lo[1] ? w_mem_word[31:16] : w_mem_word[15:0];

  // Load extraction with sign/zero extension; unknown codes behave as lw
  always_comb begin
    // NOTE: default assignment first so no path leaves the output unassigned (no latch).
    w_load_result = w_mem_word;
    case (w_ld_type)
      LD_LB:   w_load_result = {{24{w_byte[7]}}, w_byte};
      LD_LBU:  w_load_result = {24'h0, w_byte};
      LD_LH:   w_load_result = {{16{w_half[15]}}, w_half};
      LD_LHU:  w_load_result = {16'h0, w_half};
      LD_LW:   w_load_result = w_mem_word;
      default: w_load_result = w_mem_word;
    endcase
  end

  assign w_final_result = w_res_from_mem ? w_load_result : w_alu_result;

  assign ms_if.ms_allowin     = w_ms_allowin;
  assign ms_if.ms_to_ws_valid = r_ms_valid && w_ms_ready_go;
  assign ms_if.ms_to_ws_bus   = {w_gr_we, w_dest, w_final_result, w_pc};
  assign ms_if.ms_to_ds_bus   = {r_ms_valid && w_gr_we, w_dest, w_final_result};
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases with literal
// expectations plus randomized traffic checked every cycle against a
// transaction-level model (held instruction + the word it saw first).
module tb_mem_stage;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_stage_if ms_if ();
  mem_stage dut (.clk(clk), .reset(reset), .ms_if(ms_if));

  int n_cmp = 0;
  int n_bad = 0;

  // Model: what the stage holds, and the read word that belongs to it
  bit          m_valid;
  bit          m_first;
  logic [73:0] m_bus;
  logic [31:0] m_word;

  // DUT values sampled in the most recent step
  logic        s_allowin;
  logic        s_ws_valid;
  logic [69:0] s_ws_bus;
  logic [31:0] s_final;
  logic [37:0] s_ds;

  task automatic check(input string name, input logic [73:0] act, input logic [73:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [73:0] mk(input int ld, input bit rfm, input bit we,
                                     input int dest, input logic [31:0] alu,
                                     input logic [31:0] pc);
    logic [2:0] l;
    logic [4:0] d;
    l = ld[2:0];
    d = dest[4:0];
    return {l, rfm, we, d, alu, pc};
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] lt, input logic [31:0] addr,
                                           input logic [31:0] word);
    int unsigned a, b, h;
    a = addr % 4;
    b = (word >> (8 * a)) & 32'hFF;
    h = (word >> (16 * (a / 2))) & 32'hFFFF;
    case (lt)
      3'd1:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'd2:    return b;
      3'd3:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return h;
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] exp_final(input logic [73:0] b, input logic [31:0] word);
    return b[70] ? load_val(b[73:71], b[63:32], word) : b[63:32];
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_first = 0;
    m_bus   = '0;
    m_word  = '0;
  endtask

  // One clock of traffic: drive at negedge, compare against the model, advance at posedge
  task automatic step(input bit v, input logic [73:0] b, input bit wsa, input logic [31:0] rd);
    bit          ea;
    logic [31:0] word;
    logic [31:0] fin;
    @(negedge clk);
    ms_if.es_to_ms_valid  = v;
    ms_if.es_to_ms_bus    = b;
    ms_if.ws_allowin      = wsa;
    ms_if.data_sram_rdata = rd;
    #1;
    ea   = !m_valid || wsa;
    word = m_first ? rd : m_word;
    fin  = exp_final(m_bus, word);
    check("allowin", 74'(ms_if.ms_allowin), 74'(ea));
    check("ws_valid", 74'(ms_if.ms_to_ws_valid), 74'(m_valid));
    if (m_valid) begin
      check("ws_bus", 74'(ms_if.ms_to_ws_bus), 74'({m_bus[69], m_bus[68:64], fin, m_bus[31:0]}));
      check("ds_bus", 74'(ms_if.ms_to_ds_bus), 74'({m_bus[69], m_bus[68:64], fin}));
    end else begin
      check("ds_we_idle", 74'(ms_if.ms_to_ds_bus[37]), 74'(1'b0));
    end
    s_allowin  = ms_if.ms_allowin;
    s_ws_valid = ms_if.ms_to_ws_valid;
    s_ws_bus   = ms_if.ms_to_ws_bus;
    s_final    = ms_if.ms_to_ws_bus[63:32];
    s_ds       = ms_if.ms_to_ds_bus;
    @(posedge clk);
    if (!ea && m_first) m_word = rd;
    m_first = ea && v;
    if (ea) m_valid = v;
    if (ea && v) m_bus = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lt_tab  [7];
    int          a_tab   [7];
    logic [31:0] exp_tab [7];
    lt_tab  = '{1, 1, 1, 1, 2, 3, 4};
    a_tab   = '{0, 1, 2, 3, 3, 2, 0};
    exp_tab = '{32'h0000_0001, 32'h0000_007F, 32'hFFFF_FFFF, 32'hFFFF_FF80,
                32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01};

    ms_if.es_to_ms_valid  = 1'b0;
    ms_if.es_to_ms_bus    = '0;
    ms_if.ws_allowin      = 1'b1;
    ms_if.data_sram_rdata = '0;
    model_reset();

    // Reset state
    #2;
    check("rst_allowin", 74'(ms_if.ms_allowin), 74'(1'b1));
    check("rst_ws_valid", 74'(ms_if.ms_to_ws_valid), 74'(1'b0));
    check("rst_ds_bus", 74'(ms_if.ms_to_ds_bus), 74'(0));
    check("rst_ws_bus", 74'(ms_if.ms_to_ws_bus), 74'(0));
    @(negedge clk);
    reset = 1'b1;

    // Plain lw, one-cycle latency
    step(1, mk(0, 1, 1, 7, 32'h0000_0100, 32'hBFC0_0000), 1, 32'h0);
    step(0, '0, 1, 32'h8765_4321);
    check("lw_valid", 74'(s_ws_valid), 74'(1'b1));
    check("lw_ws_bus", 74'(s_ws_bus), 74'({1'b1, 5'd7, 32'h8765_4321, 32'hBFC0_0000}));

    // Byte/halfword extraction; step i carries the read word of instruction i-1
    for (int i = 0; i <= 7; i++) begin
      if (i < 7)
        step(1, mk(lt_tab[i], 1, 1, i + 1, 32'h0000_0200 | a_tab[i], 32'h1000 + 4 * i), 1, 32'h80FF_7F01);
      else
        step(0, '0, 1, 32'h80FF_7F01);
      if (i > 0) check($sformatf("ext_%0d", i - 1), 74'(s_final), 74'(exp_tab[i - 1]));
    end

    // Stall of three cycles with read data changing underneath
    step(1, mk(0, 1, 1, 3, 32'h0000_0300, 32'h2000), 1, 32'h0);
    step(0, '0, 0, 32'hDEAD_BEEF);
    check("stall1_final", 74'(s_final), 74'(32'hDEAD_BEEF));
    check("stall1_allowin", 74'(s_allowin), 74'(1'b0));
    step(0, '0, 0, 32'h1234_5678);
    check("stall2_final", 74'(s_final), 74'(32'hDEAD_BEEF));
    check("stall2_allowin", 74'(s_allowin), 74'(1'b0));
    step(0, '0, 0, 32'h1234_5678);
    check("stall3_final", 74'(s_final), 74'(32'hDEAD_BEEF));
    step(0, '0, 1, 32'h1234_5678);
    check("stall_issue_valid", 74'(s_ws_valid), 74'(1'b1));
    check("stall_issue_final", 74'(s_final), 74'(32'hDEAD_BEEF));
    step(0, '0, 1, 32'h0);
    check("stall_drained", 74'(s_ws_valid), 74'(1'b0));

    // Non-load ALU result on the bypass bus
    step(1, mk(0, 0, 1, 5, 32'h0000_0042, 32'h3000), 1, $urandom);
    step(0, '0, 1, $urandom);
    check("alu_ds_bus", 74'(s_ds), 74'({1'b1, 5'd5, 32'h0000_0042}));
    step(0, '0, 1, $urandom);
    check("alu_ds_we_empty", 74'(s_ds[37]), 74'(1'b0));

    // Four back-to-back lw, each paired with its own cycle's read word
    for (int k = 0; k <= 4; k++) begin
      step(k < 4, mk(0, 1, 1, 10 + k, 32'h400 + 4 * k, 32'h4000 + 4 * k), 1, 32'h1111_1111 * k);
      if (k > 0) begin
        check($sformatf("b2b_valid_%0d", k), 74'(s_ws_valid), 74'(1'b1));
        check($sformatf("b2b_final_%0d", k), 74'(s_final), 74'(32'h1111_1111 * k));
      end
    end

    // Randomized traffic with random back-pressure
    for (int n = 0; n < 1500; n++) begin
      logic [73:0] rb;
      rb = {$urandom, $urandom, $urandom};
      step($urandom_range(0, 3) != 0, rb, $urandom_range(0, 2) != 0, $urandom);
    end

    // Asynchronous reset between clock edges while a stalled lw is held
    step(1, mk(0, 1, 1, 9, 32'h0000_0500, 32'h5000), 1, 32'h0);
    @(negedge clk);
    ms_if.es_to_ms_valid  = 1'b0;
    ms_if.ws_allowin      = 1'b0;
    ms_if.data_sram_rdata = 32'hCAFE_F00D;
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("arst_allowin", 74'(ms_if.ms_allowin), 74'(1'b1));
    check("arst_ws_valid", 74'(ms_if.ms_to_ws_valid), 74'(1'b0));
    check("arst_ds_bus", 74'(ms_if.ms_to_ds_bus), 74'(0));
    check("arst_ws_bus", 74'(ms_if.ms_to_ws_bus), 74'(0));
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    step(0, '0, 1, 32'hCAFE_F00D);
    check("post_rst_empty", 74'(s_ws_valid), 74'(1'b0));
    step(1, mk(1, 1, 1, 2, 32'h0000_0601, 32'h6000), 1, 32'h0);
    step(0, '0, 1, 32'h0000_8000);
    check("post_rst_lb", 74'(s_final), 74'(32'hFFFF_FF80));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
